// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder with carry-in, carry-out and signed overflow. Each stage ripples one CHUNK.
// The whole pipeline advances together; out_ready low freezes every stage. in_ready is combinational from out_ready.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CHUNK = WIDTH / STAGES;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
  end

  // {carry, sum}
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  logic             v_q   [STAGES];
  logic             c_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic             ovf_q;

  logic             c_nxt [STAGES];
  logic [WIDTH-1:0] s_nxt [STAGES];
  logic             c_msb;
  logic             en;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage k adds chunk k of its operand copy on top of the sum bits already produced upstream.
  always_comb begin
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c;
    logic [1:0]       fa;
    c_msb = 1'b0;
    x     = '0;
    y     = '0;
    c     = 1'b0;
    fa    = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        x        = a;
        y        = b;
        c        = cin;
        s_nxt[k] = '0;
      end else begin
        x        = a_q[k-1];
        y        = b_q[k-1];
        c        = c_q[k-1];
        s_nxt[k] = s_q[k-1];
      end
      for (int i = 0; i < CHUNK; i++) begin
        if (k == STAGES-1 && i == CHUNK-1) c_msb = c;
        fa                    = full_add(x[k*CHUNK+i], y[k*CHUNK+i], c);
        s_nxt[k][k*CHUNK+i]   = fa[0];
        c                     = fa[1];
      end
      c_nxt[k] = c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        s_q[k] <= '0;
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (en) begin
      ovf_q <= c_nxt[STAGES-1] ^ c_msb;
      for (int k = 0; k < STAGES; k++) begin
        c_q[k] <= c_nxt[k];
        s_q[k] <= s_nxt[k];
        if (k == 0) begin
          v_q[k] <= in_valid;
          a_q[k] <= a;
          b_q[k] <= b;
        end else begin
          v_q[k] <= v_q[k-1];
          a_q[k] <= a_q[k-1];
          b_q[k] <= b_q[k-1];
        end
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed and random streams on a 16/4 instance,
// plus a random streaming sweep across several (WIDTH, STAGES) configurations.
module tb_pipelined_adder;
  localparam int S_M  = 4;
  localparam int NCFG = 5;
  localparam int CW [NCFG] = '{1, 8, 8, 32, 64};
  localparam int CS [NCFG] = '{1, 1, 8, 4, 2};
  localparam int SW_N = 40;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } res_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  logic        sw_valid;
  logic [63:0] sw_a;
  logic [63:0] sw_b;
  logic        sw_cin;
  wire  [NCFG-1:0]       sw_rdy;
  wire  [NCFG-1:0]       sw_vf;
  wire  [NCFG-1:0]       sw_co;
  wire  [NCFG-1:0]       sw_ov;
  wire  [NCFG-1:0][63:0] sw_sum;

  int   vectors     = 0;
  int   miscompares = 0;
  int   run         = 0;
  int   max_run     = 0;
  res_t exp_q [$];

  logic [15:0] ov_a [3] = '{16'h7FFF, 16'h8000, 16'h1234};
  logic [15:0] ov_b [3] = '{16'h0001, 16'h8000, 16'h4321};
  logic        ov_c [3] = '{1'b0, 1'b0, 1'b1};
  logic [15:0] ex_s [3] = '{16'h8000, 16'h0000, 16'h5556};
  logic        ex_c [3] = '{1'b0, 1'b1, 1'b0};
  logic        ex_o [3] = '{1'b1, 1'b1, 1'b0};

  logic [63:0] sa [SW_N];
  logic [63:0] sb [SW_N];
  logic        sc [SW_N];

  pipelined_adder #(.WIDTH(16), .STAGES(S_M)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  for (genvar g = 0; g < NCFG; g++) begin : g_sw
    logic [CW[g]-1:0] s;
    pipelined_adder #(.WIDTH(CW[g]), .STAGES(CS[g])) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(sw_valid), .in_ready(sw_rdy[g]),
      .a(sw_a[CW[g]-1:0]), .b(sw_b[CW[g]-1:0]), .cin(sw_cin),
      .out_valid(sw_vf[g]), .out_ready(1'b1),
      .sum(s), .cout(sw_co[g]), .ovf(sw_ov[g])
    );
    assign sw_sum[g] = 64'(s);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer addition; overflow from operand and result signs.
  function automatic void ref_add(input int w, input logic [63:0] x, input logic [63:0] y,
                                  input logic ci, output logic [63:0] s,
                                  output logic co, output logic ov);
    logic [64:0] mask;
    logic [64:0] full;
    mask = (65'd1 << w) - 65'd1;
    full = ({1'b0, x} & mask) + ({1'b0, y} & mask) + 65'(ci);
    s    = full[63:0] & mask[63:0];
    co   = full[w];
    ov   = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: score the handshakes that happen at the coming edge, then step past it.
  task automatic tick();
    logic        acc;
    logic        take;
    res_t        e;
    logic [63:0] s64;
    logic        co;
    logic        ov;
    #1;
    acc  = in_valid && in_ready && !rst;
    take = out_valid && out_ready && !rst;
    if (take) begin
      run++;
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 128'(out_valid), 128'(0));
      end else begin
        e = exp_q.pop_front();
        chk("stream_result", {sum, cout, ovf}, {e.s, e.co, e.ov});
      end
    end else begin
      if (run > max_run) max_run = run;
      run = 0;
    end
    if (acc) begin
      ref_add(16, 64'(a), 64'(b), cin, s64, co, ov);
      e.s  = s64[15:0];
      e.co = co;
      e.ov = ov;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rst) exp_q.delete();
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_left", 128'(exp_q.size()), 128'(0));
    for (int k = 0; k < S_M + 1; k++) begin
      tick();
      chk("idle_out_valid", 128'(out_valid), 128'(0));
    end
  endtask

  task automatic latency_probe(input logic [15:0] pa, input logic [15:0] pb, input logic pc);
    a = pa; b = pb; cin = pc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < S_M; k++) begin
      chk("latency_out_valid", 128'(out_valid), 128'(k == S_M - 1));
      if (k < S_M - 1) tick();
    end
  endtask

  task automatic rand_op();
    a        = 16'($urandom);
    b        = 16'($urandom);
    cin      = 1'($urandom);
    in_valid = 1'b1;
  endtask

  initial begin
    int          j;
    logic        ev;
    logic [63:0] s64;
    logic        co;
    logic        ov;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0;
    tick();
    tick();
    chk("in_ready_during_reset", 128'(in_ready), 128'(1));
    rst = 1'b0;
    chk("reset_outputs", {out_valid, sum, cout, ovf}, 128'(0));
    chk("in_ready_after_reset", 128'(in_ready), 128'(1));
    chk("sweep_in_ready", 128'(sw_rdy), 128'({NCFG{1'b1}}));

    // Carry wraps through every chunk boundary.
    latency_probe(16'hFFFF, 16'h0001, 1'b0);
    chk("carry_wrap", {sum, cout, ovf}, {16'h0000, 1'b1, 1'b0});
    drain();

    // Signed overflow vectors, back to back.
    for (int i = 0; i < 3; i++) begin
      a = ov_a[i]; b = ov_b[i]; cin = ov_c[i]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("signed_ovf", {out_valid, sum, cout, ovf}, {1'b1, ex_s[i], ex_c[i], ex_o[i]});
    end
    drain();

    // 100 random back-to-back operands.
    run = 0; max_run = 0;
    for (int i = 0; i < 100; i++) begin
      rand_op();
      tick();
    end
    drain();
    chk("stream_consecutive", 128'(max_run), 128'(100));

    // Backpressure in the middle of a stream.
    for (int i = 0; i < 6; i++) begin
      rand_op();
      tick();
    end
    rand_op();
    out_ready = 1'b0;
    #1;
    chk("in_ready_falls", 128'(in_ready), 128'(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_in_ready", 128'(in_ready), 128'(0));
      chk("stall_hold", {out_valid, sum, cout, ovf},
          {1'b1, exp_q[0].s, exp_q[0].co, exp_q[0].ov});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      rand_op();
    end
    drain();

    // Reset with three results in flight.
    for (int i = 0; i < 3; i++) begin
      rand_op();
      tick();
    end
    rand_op();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("midflight_reset_outputs", {out_valid, sum, cout, ovf}, 128'(0));
    latency_probe(16'($urandom), 16'($urandom), 1'($urandom));
    drain();

    // Configuration sweep: random stream, result of op j expected after edge j+STAGES-1.
    for (int n = 0; n < SW_N; n++) begin
      sa[n] = {$urandom, $urandom};
      sb[n] = {$urandom, $urandom};
      sc[n] = 1'($urandom);
    end
    for (int n = 0; n < SW_N + 10; n++) begin
      if (n < SW_N) begin
        sw_a = sa[n]; sw_b = sb[n]; sw_cin = sc[n]; sw_valid = 1'b1;
      end else begin
        sw_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NCFG; i++) begin
        j  = n - CS[i] + 1;
        ev = (j >= 0) && (j < SW_N);
        chk($sformatf("sweep_valid_w%0d_s%0d", CW[i], CS[i]), 128'(sw_vf[i]), 128'(ev));
        if (ev) begin
          ref_add(CW[i], sa[j], sb[j], sc[j], s64, co, ov);
          chk($sformatf("sweep_data_w%0d_s%0d", CW[i], CS[i]),
              {sw_sum[i], sw_co[i], sw_ov[i]}, {s64, co, ov});
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
